// File: rtl/tt_uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive front end.
// - rx_state_t     : receiver FSM state encoding
// - UART_DATA_BITS : payload bits per frame (8N1)
// - clog2_min1     : counter width helper that never returns 0
package tt_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tt_uart_rx_fifo_if.sv
// Byte stream from the receive FIFO to the project core.
// - rx_data  : FIFO head byte
// - rx_valid : FIFO not empty
// - rx_ready : core accepts the head byte
// Handshake: a byte moves on every clk edge where rx_valid && rx_ready are
// both high; while rx_valid && !rx_ready the producer holds rx_data stable,
// and rx_valid never depends on rx_ready.
interface tt_uart_rx_fifo_if;
  import tt_uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/tt_sync_fifo.sv
// Pointer/count synchronous FIFO with registered storage.
// - push/push_data : write request (dropped when full unless popping)
// - pop            : read request (ignored when empty)
// - head           : entry at the read pointer
// - full/empty     : occupancy flags
module tt_sync_fifo
  import tt_uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = clog2_min1(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a push onto a full FIFO
  // still lands when the head is being consumed.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tt_uart_rx_fifo.sv
// 8N1 UART receiver with a small byte FIFO, fed from ui_in[0].
// - clk, rst_n  : single clock domain, asynchronous active-low reset
// - ena         : design-select enable; low holds the receiver idle
// - rx_i        : raw asynchronous serial line, idle high
// - rx_bus      : byte stream to the core (master side)
// - frame_err   : one-cycle pulse when a stop bit is sampled low
// - overflow    : sticky, a byte was dropped on a full FIFO
// - busy        : receiver FSM not in IDLE
// - state_dbg   : current receiver FSM state
module tt_uart_rx_fifo
  import tt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      rx_i,
  tt_uart_rx_fifo_if.master         rx_bus,
  output logic                      frame_err,
  output logic                      overflow,
  output logic                      busy,
  output rx_state_t                 state_dbg
);

  localparam int CNT_W = clog2_min1(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic                      sync1, rx_s;
  rx_state_t                 state, next_state;
  logic [CNT_W-1:0]          baud_cnt;
  logic [2:0]                bit_cnt;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      tick;
  logic                      push_req, ferr_set;
  logic                      pop, fifo_full, fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_head;

  // Two-flop synchronizer; idles high like the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_i;
      rx_s  <= sync1;
    end
  end

  // First sample lands mid start bit, every later one a full bit apart.
  always_comb begin
    tick = 1'b0;
    case (state)
      START:       tick = (baud_cnt == HALF_LAST);
      DATA, STOP:  tick = (baud_cnt == FULL_LAST);
      default:     tick = 1'b0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM: next state
  always_comb begin
    next_state = state;
    if (!ena) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:      if (!rx_s) next_state = START;
        START:     if (tick) next_state = rx_s ? IDLE : DATA;
        DATA:      if (tick && bit_cnt == 3'd7) next_state = STOP;
        STOP:      if (tick) next_state = rx_s ? IDLE : WAIT_IDLE;
        // Holding here on a break keeps a low line from retriggering START.
        WAIT_IDLE: if (rx_s) next_state = IDLE;
        default:   next_state = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    push_req = ena && (state == STOP) && tick && rx_s;
    ferr_set = ena && (state == STOP) && tick && !rx_s;
    busy     = (state != IDLE);
  end

  assign state_dbg = state;

  // Baud counter, bit counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (!ena || state == IDLE || state == WAIT_IDLE) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      baud_cnt <= tick ? '0 : baud_cnt + CNT_W'(1);
      if (state == DATA && tick) begin
        shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  assign pop = rx_bus.rx_valid && rx_bus.rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      if (push_req && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  tt_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (shreg),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx_bus.rx_data  = fifo_head;
  assign rx_bus.rx_valid = !fifo_empty;

endmodule
